// File: rtl/apb_exe_master.sv
// apb_exe_master: takes one signed (a, b, op) command at a time. It runs four APB
// transfers to a remote execution unit: write A, write B, write OP, read RESULT.
// It then returns the low N bits of the read data, or an error, on the response channel.
// A slave error on any transfer aborts the remaining transfers.
// Optional feature macro: APB_MASTER_TIMEOUT_EN. When it is defined, an ACCESS phase
// still waiting on pready after TIMEOUT cycles is abandoned and reported as an error.
module apb_exe_master #(
    parameter int         N       = 8,
    parameter logic [7:0] BASE    = 8'h00,
    parameter int         TIMEOUT = 16
) (
    input  logic                pclk,
    input  logic                presetn,
    input  logic                cmd_valid,
    output logic                cmd_ready,
    input  logic signed [N-1:0] cmd_a,
    input  logic signed [N-1:0] cmd_b,
    input  logic [2:0]          cmd_op,
    output logic                rsp_valid,
    input  logic                rsp_ready,
    output logic [N-1:0]        rsp_result,
    output logic                rsp_err,
    output logic                psel,
    output logic                penable,
    output logic                pwrite,
    output logic [7:0]          paddr,
    output logic [31:0]         pwdata,
    input  logic [31:0]         prdata,
    input  logic                pready,
    input  logic                pslverr
);

    typedef enum logic [1:0] {IDLE, SETUP, ACCESS, RESP} state_t;

    state_t              state;
    logic [1:0]          step;
    logic signed [N-1:0] b_q;
    logic [2:0]          op_q;

    logic [1:0]  nxt_step;
    logic [7:0]  nxt_addr;
    logic        nxt_write;
    logic [31:0] nxt_wdata;

    // Only prdata[N-1:0] carries the result; the upper bits are intentionally dropped.
    logic unused_prdata;
    assign unused_prdata = ^prdata;

`ifdef APB_MASTER_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT + 1);
    logic [TW-1:0] tcnt;
`else
    localparam int UNUSED_TIMEOUT = TIMEOUT;
`endif

    function automatic logic [31:0] sext32(input logic signed [N-1:0] v);
        logic signed [31:0] w;
        w = v;
        return w;
    endfunction

    // Address, direction and write data of the transfer that follows the current step
    always_comb begin
        nxt_step  = step + 2'd1;
        nxt_addr  = BASE + {4'b0000, nxt_step, 2'b00};
        nxt_write = (nxt_step != 2'd3);
        case (nxt_step)
            2'd1:    nxt_wdata = sext32(b_q);
            2'd2:    nxt_wdata = {29'd0, op_q};
            default: nxt_wdata = 32'd0;
        endcase
    end

    // Command capture, APB sequencing and response hold, all as registered outputs
    always_ff @(posedge pclk) begin
        if (!presetn) begin
            state      <= IDLE;
            cmd_ready  <= 1'b1;
            psel       <= 1'b0;
            penable    <= 1'b0;
            pwrite     <= 1'b0;
            paddr      <= 8'd0;
            pwdata     <= 32'd0;
            rsp_valid  <= 1'b0;
            rsp_err    <= 1'b0;
            rsp_result <= '0;
            step       <= 2'd0;
`ifdef APB_MASTER_TIMEOUT_EN
            tcnt       <= '0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (cmd_valid && cmd_ready) begin
                        cmd_ready <= 1'b0;
                        b_q       <= cmd_b;
                        op_q      <= cmd_op;
                        step      <= 2'd0;
                        psel      <= 1'b1;
                        penable   <= 1'b0;
                        pwrite    <= 1'b1;
                        paddr     <= BASE;
                        pwdata    <= sext32(cmd_a);
                        state     <= SETUP;
                    end
                end
                SETUP: begin
                    penable <= 1'b1;
`ifdef APB_MASTER_TIMEOUT_EN
                    tcnt    <= '0;
`endif
                    state   <= ACCESS;
                end
                ACCESS: begin
                    if (pready) begin
                        if (pslverr || step == 2'd3) begin
                            // Error or final read: close the bus and present the response
                            psel       <= 1'b0;
                            penable    <= 1'b0;
                            pwrite     <= 1'b0;
                            paddr      <= 8'd0;
                            pwdata     <= 32'd0;
                            step       <= 2'd0;
                            rsp_valid  <= 1'b1;
                            rsp_err    <= pslverr;
                            rsp_result <= pslverr ? '0 : prdata[N-1:0];
                            state      <= RESP;
                        end else begin
                            step    <= nxt_step;
                            penable <= 1'b0;
                            paddr   <= nxt_addr;
                            pwrite  <= nxt_write;
                            pwdata  <= nxt_wdata;
                            state   <= SETUP;
                        end
                    end
`ifdef APB_MASTER_TIMEOUT_EN
                    else if (tcnt == TW'(TIMEOUT - 1)) begin
                        psel       <= 1'b0;
                        penable    <= 1'b0;
                        pwrite     <= 1'b0;
                        paddr      <= 8'd0;
                        pwdata     <= 32'd0;
                        step       <= 2'd0;
                        rsp_valid  <= 1'b1;
                        rsp_err    <= 1'b1;
                        rsp_result <= '0;
                        state      <= RESP;
                    end else begin
                        tcnt <= tcnt + 1'b1;
                    end
`endif
                end
                RESP: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        cmd_ready <= 1'b1;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_apb_exe_master.sv
// Scoreboard bench for apb_exe_master: random commands, a configurable APB slave,
// and a response monitor checking against a transfer-level reference model.
module tb_apb_exe_master;

    localparam logic [7:0] BASE    = 8'h20;
    localparam int         TIMEOUT = 16;

    logic              pclk = 1'b0;
    logic              presetn;
    logic              cmd_valid, cmd_ready;
    logic signed [7:0] cmd_a, cmd_b;
    logic [2:0]        cmd_op;
    logic              rsp_valid, rsp_ready, rsp_err;
    logic [7:0]        rsp_result;
    logic              psel, penable, pwrite;
    logic [7:0]        paddr;
    logic [31:0]       pwdata, prdata;
    logic              pready, pslverr;

    apb_exe_master #(.N(8), .BASE(BASE), .TIMEOUT(TIMEOUT)) dut (
        .pclk(pclk), .presetn(presetn),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_a(cmd_a), .cmd_b(cmd_b), .cmd_op(cmd_op),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_result(rsp_result), .rsp_err(rsp_err),
        .psel(psel), .penable(penable), .pwrite(pwrite), .paddr(paddr),
        .pwdata(pwdata), .prdata(prdata), .pready(pready), .pslverr(pslverr)
    );

    always #5 pclk = ~pclk;

    int cyc = 0;
    always @(posedge pclk) cyc <= cyc + 1;

    typedef struct {
        logic [7:0]  addr;
        logic        wr;
        logic [31:0] data;
        int          waits;
        logic        err;
        logic [31:0] rd;
    } xfer_t;

    typedef struct {
        logic [7:0] result;
        logic       err;
        int         lat;
        int         acc;
        int         hold;
    } rsp_t;

    xfer_t apb_q[$];
    rsp_t  rsp_q[$];

    int tests = 0;
    int fails = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference model: one command becomes a list of bus transfers plus one response.
    task automatic issue(input logic signed [7:0] a, input logic signed [7:0] b,
                         input logic [2:0] op, input int w0, input int w1, input int w2,
                         input int w3, input int erri, input logic [31:0] rd, input int hold);
        int    w[4];
        int    lat;
        int    n;
        logic  e;
        xfer_t x;
        rsp_t  r;
        w[0] = w0; w[1] = w1; w[2] = w2; w[3] = w3;
        lat = 0;
        e   = 1'b0;
        @(negedge pclk);
        cmd_valid = 1'b1; cmd_a = a; cmd_b = b; cmd_op = op;
        n = 0;
        while (!cmd_ready && n < 400) begin
            @(negedge pclk);
            n++;
        end
        chk("cmd_accept_wait", 64'(cmd_ready), 64'(1));
        for (int k = 0; k < 4; k++) begin
            x.addr  = BASE + 8'(4 * k);
            x.wr    = (k < 3);
            x.data  = (k == 0) ? 32'(int'(a)) : (k == 1) ? 32'(int'(b)) :
                      (k == 2) ? 32'(int'(op)) : 32'd0;
            x.waits = w[k];
            x.err   = (k == erri);
            x.rd    = rd;
            apb_q.push_back(x);
`ifdef APB_MASTER_TIMEOUT_EN
            if (w[k] >= TIMEOUT) begin
                lat += 1 + TIMEOUT;
                e = 1'b1;
                break;
            end
`endif
            lat += 2 + w[k];
            if (k == erri) begin
                e = 1'b1;
                break;
            end
        end
        r.err    = e;
        r.result = e ? 8'd0 : rd[7:0];
        r.lat    = lat;
        r.acc    = cyc + 1;
        r.hold   = hold;
        rsp_q.push_back(r);
        @(negedge pclk);
        cmd_valid = 1'b0;
        cmd_a = 8'($urandom); cmd_b = 8'($urandom); cmd_op = 3'($urandom);
    endtask

    // APB slave: checks each SETUP against the model and holds values through ACCESS
    initial begin
        xfer_t       cur;
        bit          have;
        int          waitleft;
        logic [7:0]  s_addr;
        logic        s_wr;
        logic [31:0] s_data;
        have = 0; waitleft = 0;
        pready = 1'b0; pslverr = 1'b0; prdata = 32'd0;
        forever begin
            @(negedge pclk);
            if (!presetn) begin
                have = 0;
                pready = 1'($urandom); pslverr = 1'($urandom); prdata = $urandom;
            end else if (psel && !penable) begin
                chk("apb_transfer_expected", 64'(apb_q.size() != 0), 64'(1));
                if (apb_q.size() != 0) begin
                    cur = apb_q.pop_front();
                    have = 1;
                    waitleft = cur.waits;
                    chk("setup_paddr", 64'(paddr), 64'(cur.addr));
                    chk("setup_pwrite", 64'(pwrite), 64'(cur.wr));
                    chk("setup_pwdata", 64'(pwdata), 64'(cur.data));
                end
                s_addr = paddr; s_wr = pwrite; s_data = pwdata;
                pready = 1'($urandom); pslverr = 1'($urandom); prdata = $urandom;
            end else if (psel && penable && have) begin
                chk("access_paddr_stable", 64'(paddr), 64'(s_addr));
                chk("access_pwrite_stable", 64'(pwrite), 64'(s_wr));
                chk("access_pwdata_stable", 64'(pwdata), 64'(s_data));
                if (waitleft > 0) begin
                    waitleft--;
                    pready = 1'b0; pslverr = 1'($urandom); prdata = $urandom;
                end else begin
                    pready = 1'b1; pslverr = cur.err; prdata = cur.rd;
                end
            end else begin
                pready = 1'($urandom); pslverr = 1'($urandom); prdata = $urandom;
            end
        end
    end

    // Response monitor: pops the scoreboard when a response appears, then drives rsp_ready
    initial begin
        bit         active;
        int         cnt;
        int         hold;
        rsp_t       e;
        logic [7:0] r0;
        logic       e0;
        active = 0; cnt = 0; hold = 0;
        rsp_ready = 1'b0;
        forever begin
            @(negedge pclk);
            if (!presetn) begin
                active = 0;
                rsp_ready = 1'($urandom);
            end else if (rsp_valid) begin
                chk("busy_cmd_ready", 64'(cmd_ready), 64'(0));
                chk("busy_psel", 64'(psel), 64'(0));
                if (!active) begin
                    active = 1; cnt = 0; hold = 0;
                    r0 = rsp_result; e0 = rsp_err;
                    chk("rsp_expected", 64'(rsp_q.size()), 64'(1));
                    if (rsp_q.size() != 0) begin
                        e = rsp_q.pop_front();
                        hold = e.hold;
                        chk("rsp_result", 64'(rsp_result), 64'(e.result));
                        chk("rsp_err", 64'(rsp_err), 64'(e.err));
                        chk("rsp_latency", 64'(cyc - e.acc), 64'(e.lat));
                    end
                end else begin
                    chk("rsp_result_stable", 64'(rsp_result), 64'(r0));
                    chk("rsp_err_stable", 64'(rsp_err), 64'(e0));
                end
                rsp_ready = (cnt >= hold);
                cnt++;
            end else begin
                if (active) chk("cmd_ready_after_handshake", 64'(cmd_ready), 64'(1));
                active = 0;
                rsp_ready = 1'($urandom);
            end
        end
    end

    // Stimulus: reset, directed scenarios, then randomized commands
    initial begin
        int n;
        int w[4];
        int erri;
        presetn = 1'b0; cmd_valid = 1'b0;
        cmd_a = 8'sd0; cmd_b = 8'sd0; cmd_op = 3'd0;
        repeat (3) @(negedge pclk);
        chk("reset_psel", 64'(psel), 64'(0));
        chk("reset_penable", 64'(penable), 64'(0));
        chk("reset_pwrite", 64'(pwrite), 64'(0));
        chk("reset_paddr", 64'(paddr), 64'(0));
        chk("reset_pwdata", 64'(pwdata), 64'(0));
        chk("reset_rsp_valid", 64'(rsp_valid), 64'(0));
        chk("reset_rsp_err", 64'(rsp_err), 64'(0));
        chk("reset_rsp_result", 64'(rsp_result), 64'(0));
        chk("reset_cmd_ready", 64'(cmd_ready), 64'(1));
        presetn = 1'b1;

        issue(-8'sd3, 8'sd5, 3'd5, 0, 0, 0, 0, 4, 32'h0000_0001, 0);
        issue(8'sd20, -8'sd7, 3'd2, 0, 3, 0, 0, 4, 32'hABCD_EF7F, 0);
        issue(-8'sd128, 8'sd127, 3'd7, 1, 0, 0, 0, 2, 32'h0000_0055, 1);
        issue(8'sd9, 8'sd1, 3'd1, 0, 0, 0, 0, 4, 32'h0000_00C3, 5);

        // Reset while write B is in its ACCESS phase: command is dropped
        issue(8'sd11, -8'sd12, 3'd3, 0, 6, 0, 0, 4, 32'h0000_0077, 0);
        n = 0;
        while (!(psel && penable && paddr == BASE + 8'h4) && n < 50) begin
            @(negedge pclk);
            n++;
        end
        chk("reached_write_b_access", 64'(psel && penable && paddr == BASE + 8'h4), 64'(1));
        presetn = 1'b0;
        apb_q.delete();
        rsp_q.delete();
        @(negedge pclk);
        chk("midreset_psel", 64'(psel), 64'(0));
        chk("midreset_penable", 64'(penable), 64'(0));
        chk("midreset_rsp_valid", 64'(rsp_valid), 64'(0));
        chk("midreset_cmd_ready", 64'(cmd_ready), 64'(1));
        presetn = 1'b1;
        repeat (3) @(negedge pclk);
        chk("postreset_rsp_valid", 64'(rsp_valid), 64'(0));

`ifdef APB_MASTER_TIMEOUT_EN
        issue(8'sd1, 8'sd2, 3'd3, 40, 0, 0, 0, 4, 32'h0000_0011, 0);
        issue(8'sd4, 8'sd5, 3'd6, 0, 0, 0, 40, 4, 32'h0000_0011, 2);
`endif

        for (int i = 0; i < 40; i++) begin
            for (int j = 0; j < 4; j++)
                w[j] = ($urandom_range(0, 2) == 0) ? int'($urandom_range(1, 5)) : 0;
            erri = ($urandom_range(0, 4) == 0) ? int'($urandom_range(0, 3)) : 4;
            issue(8'($urandom), 8'($urandom), 3'($urandom), w[0], w[1], w[2], w[3],
                  erri, $urandom, int'($urandom_range(0, 4)));
        end

        n = 0;
        while (!(rsp_q.size() == 0 && apb_q.size() == 0 && cmd_ready && !rsp_valid) && n < 500) begin
            @(negedge pclk);
            n++;
        end
        chk("drain_rsp_q", 64'(rsp_q.size()), 64'(0));
        chk("drain_apb_q", 64'(apb_q.size()), 64'(0));
        chk("drain_cmd_ready", 64'(cmd_ready), 64'(1));
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/apb_exe_master.md
APB_EXE_MASTER -- requirements
Module: apb_exe_master

Interface
REQ-001 SHALL have parameter N, default 8: operand/result width in bits.
REQ-002 SHALL have parameter BASE, default 8'h00: APB base address of the execution unit.
REQ-003 SHALL have parameter TIMEOUT, default 16: maximum ACCESS-phase cycles; used only with APB_MASTER_TIMEOUT_EN.
REQ-004 SHALL have ports pclk, in, 1: clock; all logic on the rising edge.
REQ-005 SHALL have ports presetn, in, 1: synchronous active-low reset.
REQ-006 SHALL have ports cmd_valid in 1, cmd_ready out 1, cmd_a in N signed, cmd_b in N signed, cmd_op in 3: command channel.
REQ-007 SHALL have ports rsp_valid out 1, rsp_ready in 1, rsp_result out N, rsp_err out 1: response channel.
REQ-008 SHALL have ports psel out 1, penable out 1, pwrite out 1, paddr out 8, pwdata out 32, prdata in 32, pready in 1, pslverr in 1: APB initiator.

Function
REQ-009 SHALL use this register map: A at BASE+0x0, B at BASE+0x4, OP at BASE+0x8, RESULT at BASE+0xC.
REQ-010 SHALL assert cmd_ready only in IDLE; capture cmd_a, cmd_b, cmd_op on cmd_valid && cmd_ready.
REQ-011 SHALL then run four APB transfers in fixed order: write A, write B, write OP, read RESULT.
REQ-012 SHALL sign-extend A and B to 32 bits on pwdata and zero-extend OP.
REQ-013 SHALL use per-transfer states SETUP (psel=1, penable=0, 1 cycle) and ACCESS (psel=1, penable=1, held until pready=1).
REQ-014 SHALL hold paddr, pwrite, pwdata stable from SETUP through the completing ACCESS cycle; pwdata SHALL be 0 on reads.
REQ-015 SHALL enter the next transfer's SETUP in the cycle after a completing ACCESS, with psel staying 1 and penable dropping to 0.
REQ-016 SHALL sample prdata[N-1:0] into rsp_result at the completing ACCESS of the RESULT read.
REQ-017 SHALL assert rsp_valid in the cycle after the final completing ACCESS, with psel=0, giving a minimum of 8 cycles from command accept to rsp_valid.
REQ-018 SHALL, when pslverr=1 in any completing ACCESS, skip the remaining transfers and present rsp_valid=1, rsp_err=1, rsp_result=0 next cycle.
REQ-019 SHALL hold rsp_valid, rsp_result, rsp_err stable until rsp_ready=1, return to IDLE on handshake and assert cmd_ready the following cycle.
REQ-020 SHALL ignore pready and pslverr outside ACCESS, and SHALL hold cmd_ready=0 while a command or response is outstanding.
REQ-021 SHALL implement state machine IDLE -> SETUP -> ACCESS -> (SETUP | RESP) -> IDLE, with a 2-bit step counter selecting the transfer.

Reset
REQ-022 SHALL, on any edge with presetn=0, enter IDLE and set psel=0, penable=0, pwrite=0, paddr=0, pwdata=0, rsp_valid=0, rsp_err=0, rsp_result=0, step=0.
REQ-023 SHALL set cmd_ready=1 after the reset edge.
REQ-024 SHALL, on reset mid-operation, abort the transfer in progress and drop the captured command, producing no response.

Configuration
REQ-025 SHALL, with APB_MASTER_TIMEOUT_EN defined, count ACCESS cycles and, if pready stays 0 for TIMEOUT cycles, end the transfer (psel=0) and respond as in REQ-018.
REQ-026 SHALL, without APB_MASTER_TIMEOUT_EN defined, contain no timeout counter and wait indefinitely for pready.

Verification
REQ-027 SHALL cover: cmd_a=-3, cmd_b=5, cmd_op=5, zero-wait slave returning 1 -> writes 0xFFFFFFFD, 0x5, 0x5 then read; rsp_result=8'h01 at cycle 8, rsp_err=0.
REQ-028 SHALL cover: pready low 3 cycles during write B -> pwdata/paddr stable throughout; rsp_valid at cycle 11.
REQ-029 SHALL cover: pslverr=1 on write OP -> no RESULT read issued; rsp_err=1, rsp_result=0.
REQ-030 SHALL cover: rsp_ready held low 5 cycles -> rsp_* stable, cmd_ready=0, no APB activity; cmd_ready=1 the cycle after the handshake.
REQ-031 SHALL cover: presetn=0 during ACCESS of write B -> psel=penable=0 next edge, no rsp_valid, cmd_ready=1.
REQ-032 SHALL cover: with APB_MASTER_TIMEOUT_EN and pready stuck 0 -> transfer ends after 16 ACCESS cycles with rsp_err=1.
